// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: four-requester round-robin arbiter producing a registered binary grant
// index for a downstream 2-to-4 decoder. A grant is held until the grantee pulses done or
// drops its request; every release is followed by exactly one idle cycle before the next grant.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to force a release once a grantee has held for
// MAX_HOLD cycles; the forced release raises expired for one cycle. Without the macro the hold
// counter is not built and expired is tied to 0.
//
// Parameters:
//   MAX_HOLD  - maximum grant tenure in cycles (2..255), used only with RR_ARB_TIMEOUT_EN
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req[3:0]  - request lines, bit i is requester i
//   done      - current grantee releases its grant this cycle
//   gnt_idx   - registered binary index of the current grantee
//   gnt_valid - registered, high while gnt_idx holds a live grant
//   expired   - registered one-cycle pulse on a forced (timeout) release
module rr_grant_encoder #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_encoder: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [1:0] win_idx;
  logic       win_found;
  logic       release_req;
  logic       release_any;
  logic       timeout;

  // First set request bit searching upward from ptr, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] cand;
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign release_req = done || !req[gnt_idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       expired_q, expired_d;

  // hold_q counts GRANT edges already taken; the edge that would complete MAX_HOLD
  // cycles of tenure is the one seen with hold_q == MAX_HOLD-1.
  assign timeout = (state_q == StGrant) && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d    = hold_q;
    expired_d = 1'b0;
    if (state_q == StIdle) begin
      if (win_found) hold_d = '0;
    end else begin
      hold_d = hold_q + {7'd0, (hold_q != 8'hff)};
      // A coinciding normal release takes precedence, so no expiry pulse.
      expired_d = timeout && !release_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
`else
  assign timeout = 1'b0;
  assign expired = 1'b0;
`endif

  assign release_any = release_req || timeout;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    unique case (state_q)
      StIdle: begin
        // done is meaningless without a grantee and is ignored here.
        if (win_found) begin
          state_d   = StGrant;
          gnt_idx_d = win_idx;
        end
      end
      StGrant: begin
        // Release wins over any new requests; they are arbitrated in the following idle
        // cycle against the advanced pointer.
        if (release_any) begin
          state_d = StIdle;
          ptr_d   = gnt_idx_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == StGrant);

endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed-vector bench for rr_grant_encoder with hand-computed
// expectations. Inputs change and outputs are sampled 2 time units after each rising edge.
// Define RR_ARB_TIMEOUT_EN to exercise the timeout build (MAX_HOLD=4).
module tb_rr_grant_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  int n_vec;
  int n_err;

  rr_grant_encoder #(
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] idx,
                            input logic e);
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    if (v) check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check_eq({tag, ".expired"}, 32'(expired), 32'(e));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset state, before and after clock edges.
    #3;
    check_eq("rst0.idx", 32'(gnt_idx), 32'd0);
    expect_out("rst0", 1'b0, 2'd0, 1'b0);
    tick();
    tick();
    check_eq("rst1.idx", 32'(gnt_idx), 32'd0);
    expect_out("rst1", 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Basic grant with 1-cycle latency, done release, bubble, next grant.
    req = 4'b0110;
    tick(); expect_out("basic.g1", 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    tick(); expect_out("basic.rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("basic.g2", 1'b1, 2'd2, 1'b0);

    // Grantee 2 drops its request without done: release, ptr becomes 3.
    req = 4'b0000;
    tick(); expect_out("drop.rel", 1'b0, 2'd0, 1'b0);
    tick(); expect_out("idle.hold", 1'b0, 2'd0, 1'b0);
    check_eq("idle.idx_hold", 32'(gnt_idx), 32'd2);

    // done in IDLE is ignored.
    done = 1'b1;
    tick(); expect_out("idle.done", 1'b0, 2'd0, 1'b0);
    done = 1'b0;

    // ptr=3 wins with all requests up; then wrap to 0 with req=1001.
    req = 4'b1111;
    tick(); expect_out("ptr3.g3", 1'b1, 2'd3, 1'b0);
    req  = 4'b1001;
    done = 1'b1;
    tick(); expect_out("wrap.rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("wrap.g0", 1'b1, 2'd0, 1'b0);

    // Full round: order 0,1,2,3,0 with one idle cycle between grants.
    req = 4'b1111;
    tick(); expect_out("rr.stable", 1'b1, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      done = 1'b1;
      tick(); expect_out($sformatf("rr.bubble%0d", k), 1'b0, 2'd0, 1'b0);
      done = 1'b0;
      tick(); expect_out($sformatf("rr.grant%0d", k), 1'b1, 2'(k % 4), 1'b0);
    end

    // Release 0 (ptr=1), grant 2, then asynchronous reset between edges.
    req  = 4'b0100;
    done = 1'b1;
    tick(); expect_out("pre_rst.rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("pre_rst.g2", 1'b1, 2'd2, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst.idx", 32'(gnt_idx), 32'd0);
    expect_out("arst", 1'b0, 2'd0, 1'b0);
    tick();
    req   = 4'b1000;
    rst_n = 1'b1;
    tick(); expect_out("post_rst.g3", 1'b1, 2'd3, 1'b0);

    // Hold behaviour on a single requester with no done.
    req = 4'b0000;
    tick(); expect_out("hold.rel", 1'b0, 2'd0, 1'b0);
    req = 4'b0001;
`ifdef RR_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out($sformatf("to.hold%0d", k), 1'b1, 2'd0, 1'b0);
    end
    tick(); expect_out("to.expired", 1'b0, 2'd0, 1'b1);
    tick(); expect_out("to.regrant", 1'b1, 2'd0, 1'b0);
    // done coinciding with the limit is a normal release.
    tick(); tick(); tick();
    expect_out("to.pre_lim", 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    tick(); expect_out("to.done_lim", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    tick(); expect_out("to.after", 1'b1, 2'd0, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      tick(); expect_out($sformatf("nto.hold%0d", k), 1'b1, 2'd0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_grant_encoder.md
RR_GRANT_ENCODER -- requirements
Module: rr_grant_encoder

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum grant tenure in cycles; it is used only when RR_ARB_TIMEOUT_EN is defined and legal values are 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request lines; bit i is requester i.
REQ-005 The block SHALL have port done, input, 1 bit: the current grantee releases its grant this cycle.
REQ-006 The block SHALL have port gnt_idx, output, 2 bits: binary index of the current grantee, registered; it is the select input of the downstream 2-to-4 decoder.
REQ-007 The block SHALL have port gnt_valid, output, 1 bit, registered: high while gnt_idx holds a live grant.
REQ-008 The block SHALL have port expired, output, 1 bit, registered: one-cycle pulse on forced release.

Function
REQ-009 The state machine SHALL have exactly two states: IDLE and GRANT.
REQ-010 In IDLE with req != 0 at edge N, the block SHALL enter GRANT, load gnt_idx and set gnt_valid=1, visible after edge N, giving 1-cycle latency.
REQ-011 Winner selection SHALL be round-robin: first set req bit searching upward from ptr, wrapping 3->0.
REQ-012 ptr SHALL be 2 bits and update only on release, to gnt_idx+1 modulo 4, so gnt_idx=3 gives ptr=0.
REQ-013 In IDLE with req == 0, all outputs and ptr SHALL hold, with gnt_valid=0.
REQ-014 In GRANT, gnt_idx SHALL stay stable while gnt_valid=1, regardless of other req bits.
REQ-015 Release from GRANT SHALL occur on done=1 or req[gnt_idx]=0; the next state is IDLE with gnt_valid=0 after the edge.
REQ-016 After every release, the block SHALL spend exactly one cycle in IDLE before any new grant (one-cycle bubble); back-to-back grants are therefore 1 idle cycle apart.
REQ-017 If done and new req bits occur in the same cycle, release SHALL win, and arbitration SHALL happen in the following IDLE cycle using the updated ptr.
REQ-018 done asserted while in IDLE SHALL be ignored.
REQ-019 A hold counter of 8 bits SHALL clear on grant entry and increment each GRANT cycle, saturating at 255.
REQ-020 expired SHALL be 0 except as specified in REQ-026.

Reset
REQ-021 While rst_n=0, regardless of clk, the outputs SHALL be gnt_idx=2'b00, gnt_valid=0, expired=0.
REQ-022 While rst_n=0, internal state SHALL be state=IDLE, ptr=0, hold counter=0.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt_valid immediately, asynchronously.
REQ-024 The first arbitration after reset SHALL start from ptr=0.
REQ-025 Reset deassertion SHALL be followed by normal operation on the next clk edge; no extra wait cycles.

Configuration
REQ-026 With RR_ARB_TIMEOUT_EN defined, the block SHALL force a release on the edge at which the grantee has held for MAX_HOLD cycles without releasing: gnt_valid=0, expired=1 for one cycle, ptr advanced as in REQ-012; if done coincides with the limit, the release SHALL be normal and expired SHALL stay 0.
REQ-027 Without RR_ARB_TIMEOUT_EN, the block SHALL omit the hold counter and MAX_HOLD logic, tie expired to constant 0, and hold a grant indefinitely until REQ-015.

Verification
REQ-028 The bench SHALL cover: after reset, req=4'b0110 -> next cycle gnt_idx=1, gnt_valid=1; done pulse -> gnt_valid=0 for one cycle, then gnt_idx=2.
REQ-029 The bench SHALL cover: req=4'b1111 held and done pulsed each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-030 The bench SHALL cover: grant to 3, req=4'b1001, release -> next grant is 0 (ptr wrap).
REQ-031 The bench SHALL cover: grantee 2 drops req[2] with no done -> release next edge, ptr=3.
REQ-032 The bench SHALL cover: rst_n driven low mid-grant between clock edges -> gnt_valid=0 and gnt_idx=0 immediately; after release, req=4'b1000 -> gnt_idx=3.
REQ-033 The bench SHALL cover, with RR_ARB_TIMEOUT_EN and MAX_HOLD=4: req[0] held, no done -> gnt_valid high 4 cycles, then expired=1 for 1 cycle, then gnt_idx=0 regranted after the bubble; without the macro, the grant holds for 20 cycles and expired stays 0.
